// File: rtl/dwt_decimator_fifo.sv
// dwt_decimator_fifo: parity-based 2:1 decimator feeding a circular FIFO with registered read port,
// sticky overflow flag and frame-complete pulse.
module dwt_decimator_fifo #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int KEEP_PARITY = 1,
  parameter int FRAME_LEN   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  input  logic              in_valid,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic              frame_done
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [15:0]     LAST_F   = 16'(FRAME_LEN - 1);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid, r_ovf, r_frame;
  logic [15:0]       r_fcnt;
  logic              w_keep, w_rd, w_wr, w_drop, w_flast;
  assign w_keep  = in_valid && (in_parity == 1'(KEEP_PARITY));
  assign w_rd    = rd_en && (r_count != '0);
  // A full FIFO still accepts a sample when a read frees a slot on the same edge
  assign w_wr    = w_keep && ((r_count != FULL_CNT) || w_rd);
  assign w_drop  = w_keep && (r_count == FULL_CNT) && !w_rd;
  assign w_flast = r_fcnt == LAST_F;
  always_ff @(posedge CLK)
    if (w_wr && !RST) r_mem[r_wptr] <= in_data;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_fcnt     <= '0;
      r_frame    <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr    <= r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr];
      end
      r_rd_valid <= w_rd;
      r_count    <= (w_wr && !w_rd) ? r_count + 1'b1 : (!w_wr && w_rd) ? r_count - 1'b1 : r_count;
      r_ovf      <= w_drop || (r_ovf && !clr_ovf);
      // Dropped samples still advance the frame counter to keep frame alignment
      if (w_keep) r_fcnt <= w_flast ? '0 : r_fcnt + 1'b1;
      r_frame    <= w_keep && w_flast;
    end
  end
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign count      = r_count;
  assign empty      = r_count == '0;
  assign full       = r_count == FULL_CNT;
  assign overflow   = r_ovf;
  assign frame_done = r_frame;
endmodule

// File: tb/tb_dwt_decimator_fifo.sv
// tb_dwt_decimator_fifo: scoreboard bench for dwt_decimator_fifo with default parameters.
module tb_dwt_decimator_fifo;
  logic        CLK = 0, RST = 0;
  logic [15:0] in_data = '0;
  logic        in_parity = 0, in_valid = 0, rd_en = 0, clr_ovf = 0;
  logic [15:0] rd_data;
  logic        rd_valid, empty, full, overflow, frame_done;
  logic [6:0]  count;
  int          n_chk = 0, n_fail = 0, n_frames = 0;
  int          m_cnt = 0, m_fcnt = 0;
  logic        m_frame = 0;
  logic [15:0] q[$];

  dwt_decimator_fifo dut (
    .CLK(CLK), .RST(RST), .in_data(in_data), .in_parity(in_parity), .in_valid(in_valid),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic p, input logic [15:0] d, input logic r,
                      input logic c = 1'b0);
    logic keep, rd, wr;
    in_valid = v; in_parity = p; in_data = d; rd_en = r; clr_ovf = c;
    keep = v && p;
    rd   = r && m_cnt != 0;
    wr   = keep && (m_cnt != 64 || rd);
    if (wr) q.push_back(d);
    m_frame = keep && m_fcnt == 31;
    if (keep) m_fcnt = m_frame ? 0 : m_fcnt + 1;
    m_cnt = m_cnt + int'(wr) - int'(rd);
    @(negedge CLK);
    chk("rd_valid", rd_valid, rd);
    if (rd_valid) begin
      if (q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_data", rd_data, q.pop_front());
    end
    chk("frame_done", frame_done, m_frame);
    if (frame_done) n_frames++;
    chk("count", count, m_cnt);
  endtask

  task automatic do_reset(input logic r);
    RST = 1; in_valid = 1; in_parity = 1; in_data = 16'hdead; rd_en = r; clr_ovf = 0;
    @(negedge CLK);
    RST = 0; in_valid = 0; rd_en = 0;
    q.delete(); m_cnt = 0; m_fcnt = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_frame", frame_done, 0);
  endtask

  initial begin
    @(negedge CLK);
    do_reset(0);
    for (int i = 0; i < 20; i++) step(1, (i % 2) == 0, 16'(i), 0);
    chk("dec_count", count, 10);
    chk("dec_qsize", q.size(), 10);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("dec_empty", empty, 1);
    for (int i = 0; i < 70; i++) begin
      step(1, 1, 16'(100 + i), 0);
      if (i == 62) chk("fill_notfull", full, 0);
      if (i == 63) begin chk("fill_full", full, 1); chk("fill_ovf0", overflow, 0); end
      if (i == 64) chk("fill_ovf1", overflow, 1);
    end
    step(0, 0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    step(1, 1, 16'd500, 1);
    chk("fullrw_count", count, 64);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_full", full, 1);
    for (int i = 0; i < 64; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("drain_empty", empty, 1);
    step(1, 1, 16'd777, 1);
    chk("emptyrd_count", count, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    do_reset(0);
    n_frames = 0;
    for (int i = 0; i < 200; i++) begin
      step(1, 1, 16'(16'h8000 + i), 1);
      step(1, 0, 16'hffff, 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("frame_pulses", n_frames, 6);
    chk("frame_empty", empty, 1);
    for (int i = 0; i < 65; i++) step(1, 1, 16'(i), 0);
    for (int i = 0; i < 47; i++) step(0, 0, 0, 1);
    chk("mid_count", count, 17);
    chk("mid_ovf", overflow, 1);
    do_reset(1);
    step(0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dwt_decimator_fifo.md
# dwt_decimator_fifo

Downsampling and buffering stage placed directly downstream of each DWT filter instance in the HSS-on-AIRISC datapath. It takes the filter's per-cycle output sample, parity flag and write strobe, keeps only the samples of the selected parity (factor-2 decimation), and stores them in a circular FIFO. The FIFO is drained either by the next decomposition level or by the AIRISC core through a registered read port. Frame and overflow status are reported for software sequencing.

## Interface
- DATA_W, 16, sample width (signed 1.14 fixed point, passed through unchanged)
- DEPTH, 64, FIFO depth in samples; power of two, ≥ 4
- ADDR_W, 6, log2(DEPTH)
- KEEP_PARITY, 1, parity value of the samples that are kept
- FRAME_LEN, 32, kept samples per frame; 1..65535

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- in_data  in  DATA_W  signed filter output sample
- in_parity  in  1  parity of in_data's sample index
- in_valid  in  1  filter write strobe; in_data/in_parity valid this cycle
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data is valid; one-cycle pulse per accepted read
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  ADDR_W+1  stored samples, 0..DEPTH
- overflow  out  1  sticky: a kept sample was dropped
- clr_ovf  in  1  clears overflow
- frame_done  out  1  one-cycle pulse per FRAME_LEN kept samples

## Operation
- Keep condition: keep = in_valid && (in_parity == KEEP_PARITY). Samples failing keep are ignored entirely.
- Write accept: wr = keep && (!full || rd_acc). On wr, mem[wptr] <= in_data and wptr increments mod DEPTH.
- Read accept: rd_acc = rd_en && !empty. On rd_acc, rd_data <= mem[rptr], rptr increments mod DEPTH, and rd_valid is 1 in the next cycle. Otherwise rd_valid is 0 and rd_data holds its last value.
- There is no fall-through. A read while empty is ignored even if a write lands in the same cycle.
- Count update: +1 on wr only, −1 on rd_acc only, unchanged on both or neither.
- Full with simultaneous keep and rd_acc: both are accepted, count stays DEPTH, and no overflow is flagged.
- Drop: keep && full && !rd_acc. The sample is discarded, pointers are unchanged, and overflow is set to 1.
- overflow is cleared by clr_ovf. If a drop and clr_ovf occur in the same cycle, set wins (overflow = 1).
- Frame counter: 16-bit fcnt counts keep events, including dropped ones, so frame alignment survives overflow. When fcnt == FRAME_LEN−1 on a keep, fcnt wraps to 0 and frame_done = 1 on the next cycle.
- Pointer wrap: wptr and rptr are ADDR_W bits and wrap naturally. full/empty are derived from count, not from pointer equality.
- Data is stored bit-exact. There is no arithmetic, rounding or sign handling.

## Timing
- Reset values (cycle after RST sampled high): wptr = rptr = 0, count = 0, empty = 1, full = 0, rd_data = 0, rd_valid = 0, overflow = 0, fcnt = 0, frame_done = 0. Memory contents are don't-care.
- RST mid-operation discards all stored samples and any in-flight read. Inputs in the reset cycle are ignored.
- Write-to-readable latency: a sample accepted at edge N raises empty low after edge N. rd_en in cycle N+1 yields rd_valid and rd_data in cycle N+2.
- Read latency: 1 cycle. Back-to-back rd_en sustains one sample per cycle until empty.
- count, empty, full and overflow are registered and update on the same edge as the causing event.
- Throughput: one kept sample per cycle with no stall. There is no backpressure to the filter, so loss is reported only via overflow.

## Test plan
- Reset then decimation: stream in_data = 0,1,…,19 with in_valid = 1 and in_parity alternating 1,0,… → count = 10, then 10 reads return 0,2,4,…,18 with rd_valid asserted one cycle after each rd_en.
- Fill and overflow: DEPTH = 64, write 70 kept samples 100..169 with no reads → full = 1 after the 64th, overflow = 1 from the 65th, and reads return 100..163. clr_ovf → overflow = 0.
- Full with simultaneous read/write: at count = 64, keep = 1 and rd_en = 1 in the same cycle → count stays 64, overflow stays 0, rd_data = oldest sample, and the new sample is read last.
- Empty read: rd_en = 1 while empty, with a keep in the same cycle → rd_valid = 0, count = 1; the next rd_en returns that sample.
- Frame pulse and wrap: FRAME_LEN = 32, 200 kept samples interleaved with continuous reads → frame_done pulses exactly 6 times, one cycle after kept samples 32, 64, …, 192. Pointers wrap past 63 with data intact.
- Reset mid-stream: assert RST with count = 17 and overflow = 1 → the next cycle shows count = 0, empty = 1, overflow = 0, rd_valid = 0.
